spi_config_slave: RTL and testbench
===================================

// Module: spi_config_slave
// PURPOSE
//  SPI responder (slave) for the config-bus protocol that our SPI master emits: address phase then one data byte, MSB first.
//  Oversamples SCLK/CE/SDIO in the system clock domain and decodes R/W and address.
//  Writes: presents register-write strobes. Reads: fetches reg data and shifts it out on SDO (4-wire) or SDIO (3-wire).
//  Emulates a DAC config port in loopback benches; also serves as the FPGA-side config target.
// PARAMETERS
//  SYNC_STAGES  2  flops in CE/SCLK/SDI synchronizers (>=2)
//  RD_LAT       1  clk cycles from reg_rd pulse to reg_rdata valid (1 or 2)
// PORTS
//  clk          in   1   system clock; must be >= 8x SCLK frequency
//  rst_n        in   1   synchronous reset, active-low
//  cpol         in   1   SCLK idle level; static while CE high
//  cpha         in   1   0: sample leading edge; 1: sample trailing edge
//  three_wire   in   1   1: read data driven on SDIO; 0: on SDO
//  addr_2byte   in   1   1: 16-bit address phase; 0: 8-bit
//  spi_ce       in   1   chip enable, active-low
//  spi_sclk     in   1   serial clock
//  spi_sdio_i   in   1   SDIO pad input (MOSI in 4-wire)
//  spi_sdio_o   out  1   SDIO pad output data
//  spi_sdio_oe  out  1   SDIO output enable (1 = drive)
//  spi_sdo      out  1   4-wire MISO data
//  spi_sdo_oe   out  1   MISO output enable
//  reg_addr     out  15  register address (upper bit 0 in 1-byte mode: 7 valid bits)
//  reg_wdata    out  8   write data, valid with reg_wr
//  reg_wr       out  1   1-clk write strobe
//  reg_rd       out  1   1-clk read strobe
//  reg_rdata    in   8   read data, sampled RD_LAT clks after reg_rd
//  busy         out  1   1 while synchronized CE low
//  frame_err    out  1   1-clk pulse: CE rose mid-byte
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk): all outputs 0, state S_IDLE, bit counter 0, oe's 0.
//  Edge detect on synchronized SCLK; leading edge = transition away from cpol.
//  Sample edge = leading if cpha=0 else trailing; launch edge = the other.
//  Address phase: first bit R/W (1 = read); remaining 7 or 15 bits -> reg_addr, MSB first.
//  States: S_IDLE -> (CE fall) S_ADDR -> S_RDREQ (read) | S_DATA (write) -> S_HOLD -> (CE rise) S_IDLE.
//  S_RDREQ: reg_rd pulses the clk after last addr bit sampled; reg_rdata loaded into tx shifter RD_LAT clks later.
//  Then S_DATA; oe of selected line asserted, bit7 on out.
//  Read drive: bit7 valid before its first sampling edge; each later bit on each launch edge.
//    cpha=0: bit7 driven after last addr sample, before next sampling edge.
//  Write: 8 data bits sampled; reg_wr + reg_wdata + reg_addr together 1 clk after 8th sample edge.
//  S_HOLD: further SCLK edges ignored (no strobes); outputs hold last bit; oe drops on CE rise.
//  CE rise in any state: return S_IDLE within SYNC_STAGES+1 clks; oe's 0.
//    No reg_wr for an incomplete byte; frame_err if bit count not multiple of 8 and count > 0.
//  CE rise same clk as 8th write sample: the write completes (reg_wr issued), no frame_err.
//  Mode inputs sampled at CE fall; changes mid-frame ignored.
//  Non-selected line oe always 0 (three_wire=1 -> spi_sdo_oe=0; 0 -> spi_sdio_oe=0).
// CONFIGURATION
//  SPI_SLV_STREAM_EN defined: after each data byte, reg_addr increments (wraps at 15 bits / 7 bits)
//    and S_DATA continues; reads issue a new reg_rd per byte, prefetched during bit0 of the prior byte.
//  Undefined: one data byte per frame; extra bits ignored in S_HOLD.
// STRUCTURE
//  Package spi_cfg_pkg: state encodings, RW_READ=1'b1, ADDR_W=15, DATA_W=8.
//  Sub-module spi_slv_sync: SYNC_STAGES synchronizer + rise/fall pulse for CE and SCLK, plain sync for SDI.
// TESTING
//  4-wire, mode 0, 1-byte: write addr 0x12 data 0xA5 -> one reg_wr, reg_addr=0x12, reg_wdata=0xA5.
//  3-wire, mode 3, 2-byte: read 0x0345, reg_rdata=0x3C -> reg_rd once, 0x3C on SDIO MSB first, spi_sdo_oe=0.
//  CE raised after 5 data bits of write -> no reg_wr, frame_err pulse, oe=0, busy=0.
//  rst_n low mid-read -> all outputs 0 next clk; next frame (write 0x01/0x7F) decodes correctly.
//  mode 1 vs mode 2 read at clk=8x SCLK -> master-captured byte equals reg_rdata in both.
//  STREAM_EN: write 0x7E with 3 data bytes -> reg_wr at 0x7E, 0x7F, 0x00 (1-byte wrap).

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: shared state encoding and field widths for the SPI config slave
package spi_cfg_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_RDREQ, S_DATA, S_HOLD} state_t;
  localparam logic RW_READ = 1'b1;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;
endpackage

// File: rtl/spi_slv_sync.sv
// spi_slv_sync: clk-domain synchronizers for CE/SCLK/SDI with edge pulses for CE and SCLK
module spi_slv_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ce,
  input  logic i_sclk,
  input  logic i_sdi,
  output logic o_ce_s,
  output logic o_ce_rise,
  output logic o_ce_fall,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_sdi
);
  logic [SYNC_STAGES-1:0] r_ce, r_sclk, r_sdi;
  logic r_ce_d, r_sclk_d;
  logic w_sclk_s;
  // CE resets to its idle-high level so reset release never looks like a frame start
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_ce     <= '1;
      r_sclk   <= '0;
      r_sdi    <= '0;
      r_ce_d   <= 1'b1;
      r_sclk_d <= 1'b0;
    end else begin
      r_ce     <= {r_ce[SYNC_STAGES-2:0], i_ce};
      r_sclk   <= {r_sclk[SYNC_STAGES-2:0], i_sclk};
      r_sdi    <= {r_sdi[SYNC_STAGES-2:0], i_sdi};
      r_ce_d   <= r_ce[SYNC_STAGES-1];
      r_sclk_d <= r_sclk[SYNC_STAGES-1];
    end
  assign o_ce_s      = r_ce[SYNC_STAGES-1];
  assign o_ce_rise   = o_ce_s & ~r_ce_d;
  assign o_ce_fall   = ~o_ce_s & r_ce_d;
  assign w_sclk_s    = r_sclk[SYNC_STAGES-1];
  assign o_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign o_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign o_sdi       = r_sdi[SYNC_STAGES-1];
endmodule

// File: rtl/spi_config_slave.sv
// spi_config_slave: oversampled SPI config-bus responder (R/W + 8/16-bit address + data byte).
// Define SPI_SLV_STREAM_EN for multi-byte frames with address auto-increment.
module spi_config_slave
  import spi_cfg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              three_wire,
  input  logic              addr_2byte,
  input  logic              spi_ce,
  input  logic              spi_sclk,
  input  logic              spi_sdio_i,
  output logic              spi_sdio_o,
  output logic              spi_sdio_oe,
  output logic              spi_sdo,
  output logic              spi_sdo_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              frame_err
);
  state_t r_state;
  logic [3:0] r_cnt;
  logic [14:0] r_sh;
  logic [DATA_W-1:0] r_tx, r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0] r_lat;
  logic r_rw, r_cpol, r_cpha, r_3w, r_a2, r_pend;
  logic r_out, r_sdio_oe, r_sdo_oe, r_wr, r_rd, r_busy, r_ferr;
  logic w_ce_s, w_ce_rise, w_ce_fall, w_sclk_rise, w_sclk_fall, w_sdi;
  logic w_lead, w_trail, w_samp, w_launch, w_acc, w_rw, w_wr_done, w_rd_ready;
  logic [15:0] w_word;
  logic [2:0] w_nb;
`ifdef SPI_SLV_STREAM_EN
  logic [DATA_W-1:0] r_pf;
  logic [ADDR_W-1:0] w_addr_inc;
  assign w_addr_inc = r_a2 ? r_addr + 15'd1 : {8'b0, r_addr[6:0] + 7'd1};
`endif
  spi_slv_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .i_ce(spi_ce), .i_sclk(spi_sclk), .i_sdi(spi_sdio_i),
    .o_ce_s(w_ce_s), .o_ce_rise(w_ce_rise), .o_ce_fall(w_ce_fall),
    .o_sclk_rise(w_sclk_rise), .o_sclk_fall(w_sclk_fall), .o_sdi(w_sdi)
  );
  assign w_lead     = r_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail    = r_cpol ? w_sclk_rise : w_sclk_fall;
  assign w_samp     = r_cpha ? w_trail : w_lead;
  assign w_launch   = r_cpha ? w_lead : w_trail;
  assign w_acc      = w_samp & (r_state == S_ADDR || r_state == S_DATA);
  assign w_word     = {r_sh, w_sdi};
  assign w_rw       = r_a2 ? w_word[15] : w_word[7];
  assign w_wr_done  = w_acc & (r_state == S_DATA) & (r_cnt == 4'd7) & ~r_rw;
  // phases are whole bytes, so the in-phase count mod 8 is the frame bit count mod 8
  assign w_nb       = r_cnt[2:0] + {2'b0, w_acc};
  assign w_rd_ready = r_pend & (r_lat == 2'(RD_LAT));
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sh      <= '0;
      r_tx      <= '0;
      r_wdata   <= '0;
      r_addr    <= '0;
      r_lat     <= '0;
      {r_rw, r_cpol, r_cpha, r_3w, r_a2, r_pend} <= '0;
      {r_out, r_sdio_oe, r_sdo_oe, r_wr, r_rd, r_busy, r_ferr} <= '0;
`ifdef SPI_SLV_STREAM_EN
      r_pf      <= '0;
`endif
    end else begin
      r_busy <= ~w_ce_s;
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      r_ferr <= 1'b0;
      if (r_pend) r_lat <= r_lat + 2'd1;
      if (w_ce_rise) begin
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_pend    <= 1'b0;
        r_out     <= 1'b0;
        r_sdio_oe <= 1'b0;
        r_sdo_oe  <= 1'b0;
        r_ferr    <= w_nb != 3'd0;
        if (w_wr_done) begin
          r_wr    <= 1'b1;
          r_wdata <= w_word[7:0];
        end
      end else
        case (r_state)
          S_IDLE:
            if (w_ce_fall) begin
              {r_cpol, r_cpha, r_3w, r_a2} <= {cpol, cpha, three_wire, addr_2byte};
              r_cnt   <= '0;
              r_state <= S_ADDR;
            end
          S_ADDR:
            if (w_samp) begin
              r_sh  <= w_word[14:0];
              r_cnt <= r_cnt + 4'd1;
              if (r_cnt == (r_a2 ? 4'd15 : 4'd7)) begin
                r_cnt   <= '0;
                r_rw    <= w_rw;
                r_addr  <= r_a2 ? w_word[14:0] : {8'b0, w_word[6:0]};
                r_state <= (w_rw == RW_READ) ? S_RDREQ : S_DATA;
                r_rd    <= w_rw == RW_READ;
                r_pend  <= w_rw == RW_READ;
                r_lat   <= '0;
              end
            end
          S_RDREQ:
            if (w_rd_ready) begin
              r_pend    <= 1'b0;
              r_tx      <= reg_rdata;
              r_out     <= reg_rdata[7];
              r_sdio_oe <= r_3w;
              r_sdo_oe  <= ~r_3w;
              r_state   <= S_DATA;
            end
          S_DATA: begin
            // bit7 is already on the line before the first data sample, so only shift after one
            if (w_launch && r_rw && r_cnt != 4'd0) begin
              r_tx  <= {r_tx[6:0], 1'b0};
              r_out <= r_tx[6];
            end
`ifdef SPI_SLV_STREAM_EN
            if (r_wr) r_addr <= w_addr_inc;
            if (w_rd_ready) begin
              r_pend <= 1'b0;
              r_pf   <= reg_rdata;
            end
`endif
            if (w_samp) begin
              r_sh  <= w_word[14:0];
              r_cnt <= r_cnt + 4'd1;
`ifdef SPI_SLV_STREAM_EN
              if (r_rw && r_cnt == 4'd6) begin
                r_rd   <= 1'b1;
                r_pend <= 1'b1;
                r_lat  <= '0;
                r_addr <= w_addr_inc;
              end
`endif
              if (r_cnt == 4'd7) begin
                r_cnt <= '0;
                if (!r_rw) begin
                  r_wr    <= 1'b1;
                  r_wdata <= w_word[7:0];
                end
`ifdef SPI_SLV_STREAM_EN
                if (r_rw) begin
                  r_tx  <= r_pf;
                  r_out <= r_pf[7];
                end
`else
                r_state <= S_HOLD;
`endif
              end
            end
          end
          default: ;
        endcase
    end
  assign spi_sdio_o  = r_out;
  assign spi_sdo     = r_out;
  assign spi_sdio_oe = r_sdio_oe;
  assign spi_sdo_oe  = r_sdo_oe;
  assign reg_addr    = r_addr;
  assign reg_wdata   = r_wdata;
  assign reg_wr      = r_wr;
  assign reg_rd      = r_rd;
  assign busy        = r_busy;
  assign frame_err   = r_ferr;
endmodule

// File: tb/tb_spi_config_slave.sv
// tb_spi_config_slave: SPI master model + register-file reference for spi_config_slave
module tb_spi_config_slave;
  logic clk = 0, rst_n = 0, cpol = 0, cpha = 0, three_wire = 0, addr_2byte = 0;
  logic spi_ce = 1, spi_sclk = 0, spi_sdio_i = 0;
  logic spi_sdio_o, spi_sdio_oe, spi_sdo, spi_sdo_oe, reg_wr, reg_rd, busy, frame_err;
  logic [14:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = 0;
  logic [7:0] mem [0:32767];
  logic [22:0] wq [$];
  logic [47:0] rx, sel_oe, oth_oe;
  int tests = 0, fails = 0, n_rd = 0, n_ferr = 0;
`ifdef SPI_SLV_STREAM_EN
  localparam int RD1 = 2;
`else
  localparam int RD1 = 1;
`endif

  always #5 clk = ~clk;

  spi_config_slave dut (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .three_wire(three_wire),
    .addr_2byte(addr_2byte), .spi_ce(spi_ce), .spi_sclk(spi_sclk), .spi_sdio_i(spi_sdio_i),
    .spi_sdio_o(spi_sdio_o), .spi_sdio_oe(spi_sdio_oe), .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .busy(busy), .frame_err(frame_err)
  );

  // register file answering reg_rd one clk later
  always @(posedge clk) if (reg_rd) reg_rdata <= mem[reg_addr];

  always @(negedge clk)
    if (rst_n) begin
      if (reg_wr) wq.push_back({reg_addr, reg_wdata});
      if (reg_rd) n_rd++;
      if (frame_err) n_ferr++;
    end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, want finish before 2ms");
    $fatal(1);
  end

  task automatic clear_mon();
    wq.delete();
    n_rd = 0;
    n_ferr = 0;
  endtask

  // stop: 0 = normal end, 1 = CE rises on last sample edge, 2 = leave CE low
  task automatic xfer(input logic p, input logic h, input logic tw, input logic a2,
                      input logic [47:0] tx, input int nbits, input int stop);
    cpol = p; cpha = h; three_wire = tw; addr_2byte = a2; spi_sclk = p; spi_sdio_i = 0;
    repeat (4) @(negedge clk);
    spi_ce = 0;
    repeat (4) @(negedge clk);
    rx = '0; sel_oe = '0; oth_oe = '0;
    for (int i = 0; i < nbits; i++) begin
      if (h) spi_sclk = ~p;
      spi_sdio_i = tx[nbits-1-i];
      repeat (4) @(negedge clk);
      spi_sclk = h ? p : ~p;
      rx     = {rx[46:0], tw ? spi_sdio_o : spi_sdo};
      sel_oe = {sel_oe[46:0], tw ? spi_sdio_oe : spi_sdo_oe};
      oth_oe = {oth_oe[46:0], tw ? spi_sdo_oe : spi_sdio_oe};
      if (i == nbits - 1 && stop == 1) spi_ce = 1;
      repeat (4) @(negedge clk);
      if (!h) spi_sclk = p;
    end
    if (stop != 2) begin
      spi_ce = 1;
      spi_sclk = p;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({spi_sdio_o, spi_sdio_oe, spi_sdo, spi_sdo_oe, reg_addr, reg_wdata, reg_wr, reg_rd, busy, frame_err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got nonzero outputs addr=%h wdata=%h, want all 0", reg_addr, reg_wdata);
    end
    @(negedge clk) rst_n = 1;
    repeat (5) @(negedge clk);
    tests++;
    if ({busy, spi_sdio_oe, spi_sdo_oe} !== 3'b000) begin
      fails++;
      $display("FAIL reset_idle: got busy/oe=%b, want 000", {busy, spi_sdio_oe, spi_sdo_oe});
    end
  endtask

  task automatic test_write_basic();
    logic [22:0] got;
    clear_mon();
    xfer(0, 0, 0, 0, {8'h12, 8'hA5}, 16, 0);
    tests++;
    if (wq.size() != 1) begin fails++; $display("FAIL wr_basic_count: got %0d writes, want 1", wq.size()); end
    got = (wq.size() > 0) ? wq[0] : 'x;
    tests++;
    if (got !== {15'h12, 8'hA5}) begin fails++; $display("FAIL wr_basic_data: got %h, want %h", got, {15'h12, 8'hA5}); end
    tests++;
    if (n_ferr != 0) begin fails++; $display("FAIL wr_basic_ferr: got %0d, want 0", n_ferr); end
    mem[15'h12] = 8'hA5;
  endtask

  task automatic test_read_3w();
    mem[15'h0345] = 8'h3C;
    clear_mon();
    xfer(1, 1, 1, 1, {1'b1, 15'h0345, 8'h00}, 24, 0);
    tests++;
    if (rx[7:0] !== 8'h3C) begin fails++; $display("FAIL rd3w_data: got %h, want 3c", rx[7:0]); end
    tests++;
    if (n_rd != RD1) begin fails++; $display("FAIL rd3w_rdcount: got %0d, want %0d", n_rd, RD1); end
    tests++;
    if (sel_oe[7:0] !== 8'hFF) begin fails++; $display("FAIL rd3w_sdio_oe: got %b, want ff", sel_oe[7:0]); end
    tests++;
    if (oth_oe !== '0) begin fails++; $display("FAIL rd3w_sdo_oe: got %h, want 0", oth_oe); end
    tests++;
    if (wq.size() != 0 || spi_sdio_oe !== 1'b0) begin
      fails++;
      $display("FAIL rd3w_after: got writes=%0d sdio_oe=%b, want 0/0", wq.size(), spi_sdio_oe);
    end
  endtask

  task automatic test_frame_err();
    logic p = 1'($urandom), h = 1'($urandom);
    clear_mon();
    xfer(p, h, 0, 0, {8'h33, 5'b10110}, 13, 0);
    tests++;
    if (wq.size() != 0) begin fails++; $display("FAIL ferr_nowrite: got %0d writes, want 0", wq.size()); end
    tests++;
    if (n_ferr != 1) begin fails++; $display("FAIL ferr_pulse: got %0d pulses, want 1", n_ferr); end
    tests++;
    if ({busy, spi_sdio_oe, spi_sdo_oe} !== 3'b000) begin
      fails++;
      $display("FAIL ferr_idle: got busy/oe=%b, want 000", {busy, spi_sdio_oe, spi_sdo_oe});
    end
  endtask

  task automatic test_ce_with_last();
    logic [6:0] a = 7'($urandom);
    logic [7:0] d = 8'($urandom);
    logic [22:0] got;
    clear_mon();
    xfer(1'($urandom), 1'($urandom), 0, 0, {1'b0, a, d}, 16, 1);
    got = (wq.size() > 0) ? wq[0] : 'x;
    tests++;
    if (wq.size() != 1 || got !== {8'b0, a, d}) begin
      fails++;
      $display("FAIL ce_last_write: got n=%0d %h, want 1 %h", wq.size(), got, {8'b0, a, d});
    end
    tests++;
    if (n_ferr != 0) begin fails++; $display("FAIL ce_last_ferr: got %0d, want 0", n_ferr); end
    mem[{8'b0, a}] = d;
  endtask

  task automatic test_reset_mid_read();
    logic [22:0] got;
    mem[15'h55] = 8'hC3;
    clear_mon();
    xfer(0, 0, 0, 0, {8'hD5, 3'b000}, 11, 2);
    tests++;
    if ({spi_sdo_oe, reg_addr} !== {1'b1, 15'h55}) begin
      fails++;
      $display("FAIL midrd_active: got oe=%b addr=%h, want 1 55", spi_sdo_oe, reg_addr);
    end
    @(negedge clk) rst_n = 0;
    @(posedge clk);
    #1;
    tests++;
    if ({spi_sdio_o, spi_sdio_oe, spi_sdo, spi_sdo_oe, reg_addr, reg_wdata, reg_wr, reg_rd, busy, frame_err} !== '0) begin
      fails++;
      $display("FAIL midrd_reset: got addr=%h oe=%b%b busy=%b, want all 0", reg_addr, spi_sdio_oe, spi_sdo_oe, busy);
    end
    spi_ce = 1;
    spi_sclk = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    clear_mon();
    xfer(0, 0, 0, 0, {8'h01, 8'h7F}, 16, 0);
    got = (wq.size() > 0) ? wq[0] : 'x;
    tests++;
    if (wq.size() != 1 || got !== {15'h01, 8'h7F}) begin
      fails++;
      $display("FAIL midrd_next: got n=%0d %h, want 1 %h", wq.size(), got, {15'h01, 8'h7F});
    end
    mem[15'h01] = 8'h7F;
  endtask

  task automatic test_modes_read();
    for (int m = 0; m < 2; m++) begin
      logic [6:0] a = 7'($urandom);
      logic p = (m == 1), h = (m == 0);
      mem[{8'b0, a}] = 8'($urandom);
      clear_mon();
      xfer(p, h, 0, 0, {1'b1, a, 8'h00}, 16, 0);
      tests++;
      if (rx[7:0] !== mem[{8'b0, a}]) begin
        fails++;
        $display("FAIL mode%0d_read: got %h, want %h", m ? 2 : 1, rx[7:0], mem[{8'b0, a}]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic p = 1'($urandom), h = 1'($urandom), tw = 1'($urandom), a2 = 1'($urandom), rw = 1'($urandom);
      logic [14:0] a = 15'($urandom);
      logic [7:0] d = 8'($urandom);
      logic [22:0] got;
      if (!a2) a[14:7] = '0;
      clear_mon();
      if (a2) xfer(p, h, tw, a2, {24'b0, rw, a, d}, 24, 0);
      else    xfer(p, h, tw, a2, {32'b0, rw, a[6:0], d}, 16, 0);
      if (rw) begin
        tests++;
        if (rx[7:0] !== mem[a] || sel_oe[7:0] !== 8'hFF || oth_oe !== '0 || wq.size() != 0) begin
          fails++;
          $display("FAIL rand%0d_read: got %h oe=%b oth=%h nwr=%0d, want %h ff 0 0", n, rx[7:0], sel_oe[7:0], oth_oe, wq.size(), mem[a]);
        end
      end else begin
        got = (wq.size() > 0) ? wq[0] : 'x;
        tests++;
        if (wq.size() != 1 || got !== {a, d} || n_rd != 0) begin
          fails++;
          $display("FAIL rand%0d_write: got n=%0d %h rd=%0d, want 1 %h 0", n, wq.size(), got, n_rd, {a, d});
        end
        mem[a] = d;
      end
    end
  endtask

  task automatic test_multi_byte();
    logic [22:0] got;
    clear_mon();
`ifdef SPI_SLV_STREAM_EN
    xfer(0, 0, 0, 0, {8'h7E, 8'h11, 8'h22, 8'h33}, 32, 0);
    tests++;
    if (wq.size() != 3) begin fails++; $display("FAIL stream_count: got %0d writes, want 3", wq.size()); end
    for (int k = 0; k < 3; k++) begin
      logic [22:0] want = {8'b0, 7'(7'h7E + k), 8'(8'h11 * (k + 1))};
      got = (wq.size() > k) ? wq[k] : 'x;
      tests++;
      if (got !== want) begin fails++; $display("FAIL stream_wr%0d: got %h, want %h", k, got, want); end
    end
`else
    xfer(0, 0, 0, 0, {8'h7E, 8'h11, 8'h22}, 24, 0);
    got = (wq.size() > 0) ? wq[0] : 'x;
    tests++;
    if (wq.size() != 1 || got !== {15'h7E, 8'h11}) begin
      fails++;
      $display("FAIL hold_extra: got n=%0d %h, want 1 %h", wq.size(), got, {15'h7E, 8'h11});
    end
    tests++;
    if (n_ferr != 0) begin fails++; $display("FAIL hold_ferr: got %0d, want 0", n_ferr); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    test_reset();
    test_write_basic();
    test_read_3w();
    test_frame_err();
    test_ce_with_last();
    test_reset_mid_read();
    test_modes_read();
    test_random();
    test_multi_byte();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
